// File: rtl/q1q2_seq_pkg.sv
// Shared types and defaults for the q1/q2 handshake sequencer.
// Holds the FSM state encoding and the default sizing constants.
package q1q2_seq_pkg;

  localparam int GAP_W_DEF   = 8;
  localparam int MIN_GAP_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    PH_A,
    PH_B,
    WAIT,
    PH_C,
    PH_D
  } state_t;

endpackage

// File: rtl/gap_down_counter.sv
// Loadable down-counter that times the b-to-c gap.
// Ports: clk, rst_n, load, load_val, dec in; tc out (count == 1).
module gap_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  // Loaded with gap-1; the last WAIT cycle is the one holding 1.
  assign tc = (count == W'(1));

endmodule

// File: rtl/q1_q2_sequencer.sv
// Drives a->b (q1) then c->d (q2) with a gap of at least MIN_GAP.
// Ports: clk, rst_n, start_i, gap_i, abort_i in; ready/busy/a-d/done/clamped/gap_eff out.
module q1_q2_sequencer
  import q1q2_seq_pkg::*;
#(
  parameter int GAP_W   = GAP_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  output logic             done_o,
  output logic             clamped_o,
  output logic [GAP_W-1:0] gap_eff_o
);

  localparam logic [GAP_W-1:0] MIN_V = GAP_W'(MIN_GAP);

  state_t state;
  logic   tc;
  logic   cnt_load;
  logic   cnt_dec;
  logic   low_req;

  assign low_req  = (gap_i < MIN_V);
  assign cnt_load = (state == PH_B) && !abort_i;
  assign cnt_dec  = (state == WAIT);

  gap_down_counter #(
    .W(GAP_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(gap_eff_o - GAP_W'(1)),
    .dec     (cnt_dec),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      busy_o    <= 1'b0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      c_o       <= 1'b0;
      d_o       <= 1'b0;
      done_o    <= 1'b0;
      clamped_o <= 1'b0;
      gap_eff_o <= '0;
    end else begin
      a_o    <= 1'b0;
      b_o    <= 1'b0;
      c_o    <= 1'b0;
      d_o    <= 1'b0;
      done_o <= 1'b0;
      if (state != IDLE && abort_i) begin
        state   <= IDLE;
        ready_o <= 1'b1;
        busy_o  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // abort wins over a same-cycle start
            if (start_i && !abort_i) begin
              state     <= PH_A;
              a_o       <= 1'b1;
              ready_o   <= 1'b0;
              busy_o    <= 1'b1;
              clamped_o <= low_req;
              gap_eff_o <= low_req ? MIN_V : gap_i;
            end
          end
          PH_A: begin
            state <= PH_B;
            b_o   <= 1'b1;
          end
          PH_B: begin
            state <= WAIT;
          end
          WAIT: begin
            if (tc) begin
              state <= PH_C;
              c_o   <= 1'b1;
            end
          end
          PH_C: begin
            state  <= PH_D;
            d_o    <= 1'b1;
            done_o <= 1'b1;
          end
          PH_D: begin
            state   <= IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_q1_q2_sequencer.sv
// Self-checking bench for q1_q2_sequencer.
// Model predicts each edge from accept time and effective gap.
module tb_q1_q2_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] gap_i;
  logic       abort_i;
  logic       ready_o, busy_o;
  logic       a_o, b_o, c_o, d_o, done_o;
  logic       clamped_o;
  logic [7:0] gap_eff_o;

  int checks = 0;
  int passed = 0;

  // model: edge counter, accept edge, effective gap
  int         n  = 0;
  int         mk = 0;
  int         mg = 0;
  bit         mact = 0;
  bit         mcl  = 0;
  logic [7:0] mge  = '0;

  always #5 clk = ~clk;

  q1_q2_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .gap_i    (gap_i),
    .abort_i  (abort_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .c_o      (c_o),
    .d_o      (d_o),
    .done_o   (done_o),
    .clamped_o(clamped_o),
    .gap_eff_o(gap_eff_o)
  );

  function automatic logic [15:0] obs_vec();
    return {ready_o, busy_o, a_o, b_o, c_o, d_o,
            done_o, clamped_o, gap_eff_o};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [6:0] p;
    if (mact && n <= mk + 2 + mg)
      p = {1'b0, 1'b1, n == mk, n == mk + 1,
           n == mk + 1 + mg, n == mk + 2 + mg,
           n == mk + 2 + mg};
    else
      p = 7'b1000000;
    return {p, mcl, mge};
  endfunction

  function automatic void model_rst();
    mact = 0;
    mcl  = 0;
    mge  = '0;
  endfunction

  function automatic void model_step();
    bit idle_b;
    idle_b = !(mact && n - 1 <= mk + 2 + mg);
    if (!idle_b && abort_i) begin
      mact = 0;
    end else if (idle_b && start_i && !abort_i) begin
      mk   = n;
      mg   = (gap_i < 5) ? 5 : int'(gap_i);
      mact = 1;
      mcl  = (gap_i < 5);
      mge  = 8'(mg);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    n++;
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    gap_i   = '0;
    model_rst();
    #12;
    checks++;
    if (obs_vec() !== 16'h8000)
      $display("FAIL reset got=%h exp=%h", obs_vec(), 16'h8000);
    else passed++;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_run(input string nm, input int gap, input int cyc);
    start_i = 1'b1;
    gap_i   = 8'(gap);
    tick();
    start_i = 1'b0;
    gap_i   = 8'($urandom);
    for (int i = 0; i < cyc; i++) begin
      checks++;
      if (obs_vec() !== exp_vec() || !$onehot0({a_o, b_o, c_o, d_o}))
        $display("FAIL %s cyc=%0d got=%h exp=%h",
                 nm, i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_abort();
    start_i = 1'b1;
    gap_i   = 8'd8;
    tick();
    start_i = 1'b0;
    // b on the next edge, then three WAIT cycles, then abort
    for (int i = 0; i < 5; i++) begin
      if (i == 4) abort_i = 1'b1;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL abort_pre cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    abort_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_vec() !== exp_vec() || c_o || d_o || done_o)
        $display("FAIL abort_post cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    test_run("after_abort", 6, 12);
  endtask

  task automatic test_back_to_back();
    int last_d = -100;
    start_i = 1'b1;
    gap_i   = 8'd5;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || !$onehot0({a_o, b_o, c_o, d_o}))
        $display("FAIL b2b cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
      if (d_o) last_d = i;
      if (a_o && last_d >= 0) begin
        checks++;
        if (i - last_d != 2)
          $display("FAIL b2b_space got=%0d exp=2", i - last_d);
        else passed++;
      end
    end
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset_mid();
    test_run("pre_rst", 5, 6);
    checks++;
    if (c_o !== 1'b1)
      $display("FAIL rst_mid_c got=%b exp=1", c_o);
    else passed++;
    #2;
    rst_n = 1'b0;
    model_rst();
    #1;
    checks++;
    if (obs_vec() !== 16'h8000)
      $display("FAIL rst_async got=%h exp=%h", obs_vec(), 16'h8000);
    else passed++;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || d_o)
        $display("FAIL rst_no_d cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    gap_i   = 8'd9;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_vec() !== exp_vec() || a_o || !ready_o)
        $display("FAIL start_abort cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start_i = ($urandom_range(0, 3) != 0);
      abort_i = ($urandom_range(0, 40) == 0);
      gap_i   = 8'($urandom_range(0, 12));
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || !$onehot0({a_o, b_o, c_o, d_o}))
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else passed++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    test_reset();
    test_run("gap5", 5, 12);
    test_run("gap2", 2, 12);
    test_run("gap0", 0, 12);
    test_run("gap255", 255, 262);
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
